// File: rtl/cobra_stream_core.sv
// cobra_stream_core: single-issue micro-sequencer with an external instruction ROM,
// a valid/ready switch input, a one-deep buffered output channel and a HALT state.
module cobra_stream_core #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int SW_W  = 16,
  parameter int PC_W  = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic [PC_W-1:0] pc_o,
  input  logic [31:0]     instr_i,
  input  logic [SW_W-1:0] sw_i,
  input  logic            sw_valid_i,
  output logic            sw_ready_o,
  output logic [XLEN-1:0] out_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            halted_o
);

  localparam int RA_W = $clog2(NREGS);
  localparam int SH_W = $clog2(XLEN);

  localparam logic [3:0] OP_LI   = 4'd0;
  localparam logic [3:0] OP_ALU  = 4'd1;
  localparam logic [3:0] OP_IN   = 4'd2;
  localparam logic [3:0] OP_OUT  = 4'd3;
  localparam logic [3:0] OP_BR   = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd6;

  typedef enum logic {RUN, HALT} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rf [NREGS];
  logic [XLEN-1:0]   out_data_p1;
  logic              out_vld_p1;

  logic [3:0]        op;
  logic [RA_W-1:0]   wa, ra1, ra2;
  logic [XLEN-1:0]   rd1, rd2;
  logic [XLEN-1:0]   li_val;
  logic [PC_W-1:0]   br_off, jmp_off;
  logic              we, out_load, sw_ready;
  logic [XLEN-1:0]   wdata;

  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] f,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    logic [SH_W-1:0]        sh;
    logic [XLEN-1:0]        r;
    sa = a;
    sb = b;
    sh = b[SH_W-1:0];
    case (f)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << sh;
      4'd6:    r = a >> sh;
      4'd7:    r = sa >>> sh;
      4'd8:    r = {{(XLEN-1){1'b0}}, sa < sb};
      4'd9:    r = {{(XLEN-1){1'b0}}, a < b};
      4'd10:   r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic br_taken(input logic [2:0] cond,
                                    input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    sa = a;
    sb = b;
    case (cond)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return sa < sb;
      3'd3:    return sa >= sb;
      3'd4:    return a < b;
      3'd5:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  assign op      = instr_i[31:28];
  assign wa      = instr_i[23 +: RA_W];
  assign ra1     = instr_i[18 +: RA_W];
  assign ra2     = instr_i[13 +: RA_W];
  assign rd1     = (ra1 == '0) ? '0 : rf[ra1];
  assign rd2     = (ra2 == '0) ? '0 : rf[ra2];
  assign li_val  = XLEN'($signed(instr_i[22:0]));
  assign br_off  = PC_W'($signed(instr_i[9:0]));
  assign jmp_off = PC_W'($signed(instr_i[22:0]));

  // Execute: every instruction retires in one cycle unless IN or OUT stalls, which just holds the PC.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    we       = 1'b0;
    wdata    = '0;
    out_load = 1'b0;
    sw_ready = 1'b0;
    if (state_q == RUN) begin
      case (op)
        OP_LI: begin
          we    = 1'b1;
          wdata = li_val;
          pc_d  = pc_q + PC_W'(1);
        end
        OP_ALU: begin
          we    = 1'b1;
          wdata = alu_f(instr_i[3:0], rd1, rd2);
          pc_d  = pc_q + PC_W'(1);
        end
        OP_IN: begin
          sw_ready = 1'b1;
          if (sw_valid_i) begin
            we    = 1'b1;
            wdata = XLEN'(sw_i);
            pc_d  = pc_q + PC_W'(1);
          end
        end
        OP_OUT: begin
          if (!out_vld_p1 || out_ready_i) begin
            out_load = 1'b1;
            pc_d     = pc_q + PC_W'(1);
          end
        end
        OP_BR:   pc_d = br_taken(instr_i[12:10], rd1, rd2) ? pc_q + br_off : pc_q + PC_W'(1);
        OP_JMP:  pc_d = pc_q + jmp_off;
        OP_HALT: state_d = HALT;
        default: pc_d = pc_q + PC_W'(1);
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      pc_q    <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (we && wa != '0) rf[wa] <= wdata;
    end
  end

  // Output stage: one-deep buffer; a simultaneous drain and load keeps valid high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_data_p1 <= '0;
      out_vld_p1  <= 1'b0;
    end else if (out_load) begin
      out_data_p1 <= rd1;
      out_vld_p1  <= 1'b1;
    end else if (out_vld_p1 && out_ready_i) begin
      out_vld_p1  <= 1'b0;
    end
  end

  assign pc_o        = pc_q;
  assign sw_ready_o  = sw_ready;
  assign out_o       = out_data_p1;
  assign out_valid_o = out_vld_p1;
  assign halted_o    = (state_q == HALT);

endmodule

// File: tb/tb_cobra_stream_core.sv
// Directed bench for cobra_stream_core: ALU and branch vector tables plus
// hand-written stall, handshake, halt, jump and reset sequences.
module tb_cobra_stream_core;

  localparam logic [31:0] I_HALT = 32'h6000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [9:0]  pc_a;
  logic [31:0] instr_a;
  logic [15:0] sw_a = '0;
  logic        sw_vld_a = 1'b0;
  logic        sw_rdy_a;
  logic [31:0] out_a;
  logic        out_vld_a;
  logic        out_rdy_a = 1'b0;
  logic        halted_a;

  logic [9:0]  pc_b;
  logic [31:0] instr_b;
  logic [15:0] sw_b = '0;
  logic        sw_vld_b = 1'b0;
  logic        sw_rdy_b;
  logic [15:0] out_b;
  logic        out_vld_b;
  logic        out_rdy_b = 1'b1;
  logic        halted_b;

  logic [31:0] rom_a [1024];
  logic [31:0] rom_b [1024];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  assign instr_a = rom_a[pc_a];
  assign instr_b = rom_b[pc_b];

  cobra_stream_core dut_a (
    .clk_i(clk), .rst_ni(rst_n), .pc_o(pc_a), .instr_i(instr_a),
    .sw_i(sw_a), .sw_valid_i(sw_vld_a), .sw_ready_o(sw_rdy_a),
    .out_o(out_a), .out_valid_o(out_vld_a), .out_ready_i(out_rdy_a),
    .halted_o(halted_a)
  );

  cobra_stream_core #(.XLEN(16), .NREGS(8), .SW_W(16), .PC_W(10)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .pc_o(pc_b), .instr_i(instr_b),
    .sw_i(sw_b), .sw_valid_i(sw_vld_b), .sw_ready_o(sw_rdy_b),
    .out_o(out_b), .out_valid_o(out_vld_b), .out_ready_i(out_rdy_b),
    .halted_o(halted_b)
  );

  function automatic logic [31:0] enc_li(input int wa, input int imm);
    return {4'd0, wa[4:0], imm[22:0]};
  endfunction
  function automatic logic [31:0] enc_alu(input int wa, input int r1, input int r2, input int f);
    return {4'd1, wa[4:0], r1[4:0], r2[4:0], 9'd0, f[3:0]};
  endfunction
  function automatic logic [31:0] enc_in(input int wa);
    return {4'd2, wa[4:0], 23'd0};
  endfunction
  function automatic logic [31:0] enc_out(input int r1);
    return {4'd3, 5'd0, r1[4:0], 18'd0};
  endfunction
  function automatic logic [31:0] enc_br(input int cond, input int r1, input int r2, input int off);
    return {4'd4, 5'd0, r1[4:0], r2[4:0], cond[2:0], off[9:0]};
  endfunction
  function automatic logic [31:0] enc_jmp(input int off);
    return {4'd5, 5'd0, off[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic clr_rom();
    for (int i = 0; i < 1024; i++) rom_a[i] = I_HALT;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    string       name;
    int          f;
    int          a;
    int          b;
    logic [31:0] exp;
  } alu_vec_t;

  typedef struct {
    string name;
    int    cond;
    int    a;
    int    b;
    int    exp_pc;
  } br_vec_t;

  alu_vec_t av[15];
  br_vec_t  bv[10];

  initial begin
    int subs;

    av[0]  = '{"add",       0,  5,       -3,      32'h0000_0002};
    av[1]  = '{"sub_wrap",  1,  5,       7,       32'hFFFF_FFFE};
    av[2]  = '{"and",       2,  12,      10,      32'h0000_0008};
    av[3]  = '{"or",        3,  12,      10,      32'h0000_000E};
    av[4]  = '{"xor",       4,  12,      10,      32'h0000_0006};
    av[5]  = '{"sll31",     5,  1,       31,      32'h8000_0000};
    av[6]  = '{"sll_amt33", 5,  1,       33,      32'h0000_0002};
    av[7]  = '{"srl",       6,  -1,      28,      32'h0000_000F};
    av[8]  = '{"sra",       7,  -16,     2,       32'hFFFF_FFFC};
    av[9]  = '{"slt_1_m1",  8,  1,       -1,      32'h0000_0000};
    av[10] = '{"slt_m1_1",  8,  -1,      1,       32'h0000_0001};
    av[11] = '{"sltu_1_m1", 9,  1,       -1,      32'h0000_0001};
    av[12] = '{"mul_ovf",   10, 'h10000, 'h10000, 32'h0000_0000};
    av[13] = '{"mul_neg",   10, 7,       -3,      32'hFFFF_FFEB};
    av[14] = '{"f_undef",   11, 5,       3,       32'h0000_0000};

    bv[0] = '{"beq_t",   0, 5,  5,  4};
    bv[1] = '{"beq_n",   0, 5,  6,  3};
    bv[2] = '{"bne_t",   1, 5,  6,  4};
    bv[3] = '{"blt_t",   2, -1, 1,  4};
    bv[4] = '{"blt_n",   2, 1,  -1, 3};
    bv[5] = '{"bge_t",   3, 1,  -1, 4};
    bv[6] = '{"bltu_t",  4, 1,  -1, 4};
    bv[7] = '{"bgeu_n",  5, 1,  -1, 3};
    bv[8] = '{"bcond6",  6, 5,  5,  3};
    bv[9] = '{"bcond7",  7, 5,  5,  3};

    for (int i = 0; i < 1024; i++) rom_b[i] = I_HALT;
    rom_b[0] = enc_li(1, 5);
    rom_b[1] = enc_li(2, -3);
    rom_b[2] = enc_alu(3, 1, 2, 0);
    rom_b[3] = enc_out(3);

    // Scenario 1: LI/LI/ADD/OUT on both widths, plus reset state.
    clr_rom();
    rom_a[0] = enc_li(1, 5);
    rom_a[1] = enc_li(2, -3);
    rom_a[2] = enc_alu(3, 1, 2, 0);
    rom_a[3] = enc_out(3);
    out_rdy_a = 1'b1;
    do_reset();
    chk("rst_pc", 32'(pc_a), 32'd0);
    chk("rst_out", out_a, 32'd0);
    chk("rst_out_vld", 32'(out_vld_a), 32'd0);
    chk("rst_halted", 32'(halted_a), 32'd0);
    step(4);
    chk("s1_pc", 32'(pc_a), 32'd4);
    chk("s1_out", out_a, 32'd2);
    chk("s1_out_vld", 32'(out_vld_a), 32'd1);
    chk("s1b_pc", 32'(pc_b), 32'd4);
    chk("s1b_out", 32'(out_b), 32'd2);
    chk("s1b_out_vld", 32'(out_vld_b), 32'd1);
    step(1);
    chk("s1_out_drain", 32'(out_vld_a), 32'd0);
    chk("s1_halted", 32'(halted_a), 32'd1);
    chk("s1b_out_drain", 32'(out_vld_b), 32'd0);
    chk("s1b_halted", 32'(halted_b), 32'd1);
    chk("s1b_sw_rdy", 32'(sw_rdy_b), 32'd0);

    // ALU table
    out_rdy_a = 1'b0;
    foreach (av[k]) begin
      clr_rom();
      rom_a[0] = enc_li(1, av[k].a);
      rom_a[1] = enc_li(2, av[k].b);
      rom_a[2] = enc_alu(3, 1, 2, av[k].f);
      rom_a[3] = enc_out(3);
      do_reset();
      step(4);
      chk(av[k].name, out_a, av[k].exp);
      chk({av[k].name, "_vld"}, 32'(out_vld_a), 32'd1);
    end

    // Branch table
    foreach (bv[k]) begin
      clr_rom();
      rom_a[0] = enc_li(1, bv[k].a);
      rom_a[1] = enc_li(2, bv[k].b);
      rom_a[2] = enc_br(bv[k].cond, 1, 2, 2);
      do_reset();
      step(3);
      chk(bv[k].name, 32'(pc_a), 32'(bv[k].exp_pc));
    end

    // IN stall then handshake
    clr_rom();
    rom_a[0] = enc_in(1);
    rom_a[1] = enc_out(1);
    sw_vld_a = 1'b0;
    out_rdy_a = 1'b0;
    do_reset();
    chk("in_rdy0", 32'(sw_rdy_a), 32'd1);
    step(3);
    chk("in_stall_pc", 32'(pc_a), 32'd0);
    chk("in_stall_rdy", 32'(sw_rdy_a), 32'd1);
    sw_a = 16'h0f0c;
    sw_vld_a = 1'b1;
    step(1);
    sw_vld_a = 1'b0;
    chk("in_done_pc", 32'(pc_a), 32'd1);
    chk("in_done_rdy", 32'(sw_rdy_a), 32'd0);
    step(1);
    chk("in_value", out_a, 32'h0000_0f0c);

    // Back-to-back OUT with stalled sink
    clr_rom();
    rom_a[0] = enc_li(1, 7);
    rom_a[1] = enc_li(2, 9);
    rom_a[2] = enc_out(1);
    rom_a[3] = enc_out(2);
    out_rdy_a = 1'b0;
    do_reset();
    step(3);
    chk("o2_first", out_a, 32'd7);
    chk("o2_first_vld", 32'(out_vld_a), 32'd1);
    step(2);
    chk("o2_stall_pc", 32'(pc_a), 32'd3);
    chk("o2_stall_out", out_a, 32'd7);
    out_rdy_a = 1'b1;
    step(1);
    out_rdy_a = 1'b0;
    chk("o2_second", out_a, 32'd9);
    chk("o2_no_gap", 32'(out_vld_a), 32'd1);
    chk("o2_pc", 32'(pc_a), 32'd4);

    // Countdown loop to HALT
    clr_rom();
    rom_a[0] = enc_li(4, 1);
    rom_a[1] = enc_li(1, 3);
    rom_a[2] = enc_alu(1, 1, 4, 1);
    rom_a[3] = enc_br(1, 1, 0, -1);
    do_reset();
    subs = 0;
    for (int c = 0; c < 60; c++) begin
      step(1);
      if (pc_a == 10'd2) subs++;
      if (halted_a) break;
    end
    chk("loop_halted", 32'(halted_a), 32'd1);
    chk("loop_subs", 32'(subs), 32'd3);
    chk("loop_pc", 32'(pc_a), 32'd4);
    sw_vld_a = 1'b1;
    step(3);
    sw_vld_a = 1'b0;
    chk("halt_pc_frozen", 32'(pc_a), 32'd4);
    chk("halt_sw_rdy", 32'(sw_rdy_a), 32'd0);

    // SRA of 0x80000000 by 31
    clr_rom();
    rom_a[0] = enc_li(1, 1);
    rom_a[1] = enc_li(2, 31);
    rom_a[2] = enc_alu(1, 1, 2, 5);
    rom_a[3] = enc_alu(3, 1, 2, 7);
    rom_a[4] = enc_out(3);
    do_reset();
    step(5);
    chk("sra_msb", out_a, 32'hFFFF_FFFF);

    // r0 stays zero
    clr_rom();
    rom_a[0] = enc_li(0, 5);
    rom_a[1] = enc_li(1, 9);
    rom_a[2] = enc_out(1);
    rom_a[3] = enc_out(0);
    out_rdy_a = 1'b1;
    do_reset();
    step(3);
    chk("r0_pre", out_a, 32'd9);
    step(1);
    chk("r0_zero", out_a, 32'd0);
    chk("r0_vld", 32'(out_vld_a), 32'd1);
    out_rdy_a = 1'b0;

    // JMP -1 wraps PC
    clr_rom();
    rom_a[0] = enc_jmp(-1);
    do_reset();
    step(1);
    chk("jmp_wrap", 32'(pc_a), 32'd1023);
    step(1);
    chk("jmp_halt", 32'(halted_a), 32'd1);

    // Async reset during IN stall with a pending output
    clr_rom();
    rom_a[0] = enc_li(1, 3);
    rom_a[1] = enc_out(1);
    rom_a[2] = enc_in(2);
    sw_vld_a = 1'b0;
    out_rdy_a = 1'b0;
    do_reset();
    step(4);
    chk("ar_pre_pc", 32'(pc_a), 32'd2);
    chk("ar_pre_vld", 32'(out_vld_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_pc", 32'(pc_a), 32'd0);
    chk("ar_vld", 32'(out_vld_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
